// File: rtl/fpm_pkg.sv
// Shared types and constants for the pipelined FP multiplier.
package fpm_pkg;

  // Operand classification after subnormal flushing.
  typedef enum logic [2:0] {
    ZERO,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  // Bit positions inside the 4-bit flags word {invalid, overflow, underflow, inexact}.
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Exponent bias for an exponent field of exp_w bits.
  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // All-ones exponent value (infinity / NaN encoding).
  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fpm_pipe_if.sv
// Operand/result streaming bus of the FP multiplier.
interface fpm_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  // Producer/consumer side.
  modport master (
    output in_valid, num1, num2, out_ready,
    input  in_ready, out_valid, result, flags
  );

  // Multiplier side.
  modport slave (
    input  in_valid, num1, num2, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fpm_unpack.sv
// Splits an FP word into sign, exponent, significand with hidden bit and class.
module fpm_unpack
  import fpm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] num,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W:0]       sig,
  output fp_class_e            cls
);
  logic [MAN_W-1:0] frac;

  assign sign = num[EXP_W+MAN_W];
  assign exp  = num[MAN_W +: EXP_W];
  assign frac = num[MAN_W-1:0];
  assign sig  = {1'b1, frac};

  // Classify; a zero exponent covers subnormals, which are flushed to zero.
  always_comb begin
    cls = NORM;
    if (exp == '0) begin
      cls = ZERO;
    end else if (exp == '1) begin
      if (frac == '0)            cls = INF;
      else if (frac[MAN_W-1])    cls = QNAN;
      else                       cls = SNAN;
    end
  end
endmodule

// File: rtl/fpm_pipe.sv
// Three-stage IEEE-754 multiplier: S1 classify/exponent, S2 multiply, S3 round/pack.
module fpm_pipe
  import fpm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic       clk,
  input logic       rst_n,
  fpm_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_E = EW'(exp_bias(EXP_W));
  localparam logic signed [EW-1:0] EMAX_E = EW'(exp_max(EXP_W));
  localparam logic signed [EW-1:0] ZERO_E = '0;
  localparam logic [EXP_W-1:0]     EMAX_F = '1;
  localparam logic [W-1:0]         QNAN_W = {1'b0, EMAX_F, 1'b1, {(MAN_W-1){1'b0}}};

  // A held output stalls every stage at once; no stage may advance alone.
  logic stall, advance;
  logic out_valid_reg;
  assign stall        = out_valid_reg & ~bus.out_ready;
  assign advance      = ~stall;
  assign bus.in_ready = advance;

  // Operand unpacking, one unit per operand.
  logic [W-1:0]     op     [2];
  logic             u_sign [2];
  logic [EXP_W-1:0] u_exp  [2];
  logic [MAN_W:0]   u_sig  [2];
  fp_class_e        u_cls  [2];
  assign op[0] = bus.num1;
  assign op[1] = bus.num2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    fpm_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack (
      .num (op[gi]),
      .sign(u_sign[gi]),
      .exp (u_exp[gi]),
      .sig (u_sig[gi]),
      .cls (u_cls[gi])
    );
  end

  // S1 decisions: special-case result is fully resolved here and carried along.
  logic                 sgn_next, sp_next;
  logic [W-1:0]         spres_next;
  logic [3:0]           spflg_next;
  logic signed [EW-1:0] e_next;
  logic                 nan_any, zero_any, inf_any;

  // Resolve specials by priority: NaN, INF*ZERO, INF, ZERO, else arithmetic path.
  always_comb begin
    sgn_next   = u_sign[0] ^ u_sign[1];
    sp_next    = 1'b1;
    spres_next = '0;
    spflg_next = '0;
    e_next     = $signed({2'b00, u_exp[0]}) + $signed({2'b00, u_exp[1]}) - BIAS_E;
    nan_any    = (u_cls[0] inside {QNAN, SNAN}) | (u_cls[1] inside {QNAN, SNAN});
    zero_any   = (u_cls[0] == ZERO) | (u_cls[1] == ZERO);
    inf_any    = (u_cls[0] == INF) | (u_cls[1] == INF);
    if (nan_any) begin
      spres_next          = QNAN_W;
      spflg_next[FLG_INV] = (u_cls[0] == SNAN) | (u_cls[1] == SNAN);
    end else if (inf_any && zero_any) begin
      spres_next          = QNAN_W;
      spflg_next[FLG_INV] = 1'b1;
    end else if (inf_any) begin
      spres_next = {sgn_next, EMAX_F, {MAN_W{1'b0}}};
    end else if (zero_any) begin
      spres_next = {sgn_next, {(W-1){1'b0}}};
    end else begin
      sp_next = 1'b0;
    end
  end

  logic                 v1_reg, sgn1_reg, sp1_reg;
  logic [W-1:0]         res1_reg;
  logic [3:0]           flg1_reg;
  logic signed [EW-1:0] e1_reg;
  logic [SW-1:0]        siga1_reg, sigb1_reg;

  // S1 register: classification, sign and biased exponent sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg <= 1'b0; sgn1_reg <= 1'b0; sp1_reg <= 1'b0;
      res1_reg <= '0; flg1_reg <= '0; e1_reg <= '0;
      siga1_reg <= '0; sigb1_reg <= '0;
    end else if (advance) begin
      v1_reg <= bus.in_valid; sgn1_reg <= sgn_next; sp1_reg <= sp_next;
      res1_reg <= spres_next; flg1_reg <= spflg_next; e1_reg <= e_next;
      siga1_reg <= u_sig[0]; sigb1_reg <= u_sig[1];
    end
  end

  logic                 v2_reg, sgn2_reg, sp2_reg;
  logic [W-1:0]         res2_reg;
  logic [3:0]           flg2_reg;
  logic signed [EW-1:0] e2_reg;
  logic [PW-1:0]        prod2_reg;

  // S2 register: full-width significand product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg <= 1'b0; sgn2_reg <= 1'b0; sp2_reg <= 1'b0;
      res2_reg <= '0; flg2_reg <= '0; e2_reg <= '0; prod2_reg <= '0;
    end else if (advance) begin
      v2_reg <= v1_reg; sgn2_reg <= sgn1_reg; sp2_reg <= sp1_reg;
      res2_reg <= res1_reg; flg2_reg <= flg1_reg; e2_reg <= e1_reg;
      prod2_reg <= PW'(siga1_reg) * PW'(sigb1_reg);
    end
  end

  logic [PW-1:0]        norm;
  logic signed [EW-1:0] e_adj, e_fin;
  logic [MAN_W-1:0]     mant;
  logic                 guard, sticky, inc;
  logic [MAN_W:0]       rnd;
  logic [W-1:0]         res_next;
  logic [3:0]           flg_next;

  // S3 logic: put the hidden bit at the MSB, round to nearest even, check range.
  always_comb begin
    norm   = prod2_reg[PW-1] ? prod2_reg : (prod2_reg << 1);
    e_adj  = e2_reg + {{(EW-1){1'b0}}, prod2_reg[PW-1]};
    mant   = norm[PW-2 -: MAN_W];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    inc    = guard & (sticky | mant[0]);
    rnd    = {1'b0, mant} + {{MAN_W{1'b0}}, inc};
    e_fin  = e_adj + {{(EW-1){1'b0}}, rnd[MAN_W]};
    res_next = '0;
    flg_next = '0;
    if (sp2_reg) begin
      res_next = res2_reg;
      flg_next = flg2_reg;
    end else if (e_fin >= EMAX_E) begin
      res_next           = {sgn2_reg, EMAX_F, {MAN_W{1'b0}}};
      flg_next[FLG_OVF]  = 1'b1;
      flg_next[FLG_INX]  = 1'b1;
    end else if (e_fin <= ZERO_E) begin
      res_next           = {sgn2_reg, {(W-1){1'b0}}};
      flg_next[FLG_UNF]  = 1'b1;
      flg_next[FLG_INX]  = 1'b1;
    end else begin
      res_next           = {sgn2_reg, e_fin[EXP_W-1:0], rnd[MAN_W-1:0]};
      flg_next[FLG_INX]  = guard | sticky;
    end
  end

  logic [W-1:0] result_reg;
  logic [3:0]   flags_reg;

  // S3 register: the output holding register seen by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0; result_reg <= '0; flags_reg <= '0;
    end else if (advance) begin
      out_valid_reg <= v2_reg; result_reg <= res_next; flags_reg <= flg_next;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.flags     = flags_reg;
endmodule

// File: tb/tb_fpm_pipe.sv
// Scoreboard bench for fpm_pipe at binary32 and binary16.
module tb_fpm_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpm_pipe_if #(.EXP_W(8), .MAN_W(23)) bus32();
  fpm_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16();

  fpm_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  fpm_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int checks = 0;
  int errors = 0;
  logic [35:0] q32[$];
  logic [19:0] q16[$];
  logic [35:0] held32;
  bit          held32_v = 1'b0;

  // Issue one binary32 op, expected {result, flags} enters the scoreboard at acceptance.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f);
    int n = 0;
    bus32.in_valid = 1'b1; bus32.num1 = a; bus32.num2 = b;
    forever begin
      @(negedge clk);
      if (bus32.in_ready) begin q32.push_back({r, f}); break; end
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL issue32_timeout a=%h b=%h in_ready never rose", a, b);
        break;
      end
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] r, input logic [3:0] f);
    int n = 0;
    bus16.in_valid = 1'b1; bus16.num1 = a; bus16.num2 = b;
    forever begin
      @(negedge clk);
      if (bus16.in_ready) begin q16.push_back({r, f}); break; end
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL issue16_timeout a=%h b=%h in_ready never rose", a, b);
        break;
      end
    end
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 100) begin
      @(posedge clk); n++;
    end
    checks++;
    if (q32.size() != 0 || q16.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending results want 0/0", q32.size(), q16.size());
    end
    @(posedge clk); #1;
  endtask

  // binary32 monitor: compares accepted outputs, checks stall behaviour.
  always @(negedge clk) begin
    if (rst_n && bus32.out_valid) begin
      if (held32_v) begin
        checks++;
        if ({bus32.result, bus32.flags} !== held32) begin
          errors++;
          $display("FAIL hold32 got %h want %h", {bus32.result, bus32.flags}, held32);
        end
      end
      if (!bus32.out_ready) begin
        checks++;
        if (bus32.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_stall got %b want 0", bus32.in_ready);
        end
        held32   = {bus32.result, bus32.flags};
        held32_v = 1'b1;
      end else begin
        held32_v = 1'b0;
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL out32_unexpected got %h/%h want nothing", bus32.result, bus32.flags);
        end else begin
          logic [35:0] e;
          e = q32.pop_front();
          if ({bus32.result, bus32.flags} !== e) begin
            errors++;
            $display("FAIL out32 got %h/%h want %h/%h", bus32.result, bus32.flags, e[35:4], e[3:0]);
          end
        end
      end
    end
  end

  // binary16 monitor (consumer always ready).
  always @(negedge clk) begin
    if (rst_n && bus16.out_valid && bus16.out_ready) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL out16_unexpected got %h/%h want nothing", bus16.result, bus16.flags);
      end else begin
        logic [19:0] e;
        e = q16.pop_front();
        if ({bus16.result, bus16.flags} !== e) begin
          errors++;
          $display("FAIL out16 got %h/%h want %h/%h", bus16.result, bus16.flags, e[19:4], e[3:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus32.in_valid = 1'b0; bus32.num1 = '0; bus32.num2 = '0; bus32.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.num1 = '0; bus16.num2 = '0; bus16.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus32.out_valid), 32'd0);
    chk("rst_result", bus32.result, 32'd0);
    chk("rst_flags", 32'(bus32.flags), 32'd0);
    chk("rst_in_ready", 32'(bus32.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed binary32 vectors, back to back.
    issue32(32'h40800000, 32'h40A00000, 32'h41A00000, 4'b0000);
    issue32(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
    issue32(32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001);
    issue32(32'h3F800800, 32'h3F801800, 32'h3F802002, 4'b0001);
    issue32(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    issue32(32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
    issue32(32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
    issue32(32'h80000000, 32'h40A10020, 32'h80000000, 4'b0000);
    issue32(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
    issue32(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
    issue32(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    issue32(32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
    issue32(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001);
    issue16(16'h4400, 16'h4500, 16'h4D00, 4'b0000);
    issue16(16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);
    drain();

    // Backpressure: six back-to-back ops with the consumer stalled for 5 cycles.
    fork
      begin
        issue32(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000);
        issue32(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
        issue32(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000);
        issue32(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
        issue32(32'h40800000, 32'h40A00000, 32'h41A00000, 4'b0000);
        issue32(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus32.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus32.out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with ops in flight, one of them already presented.
    issue32(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000);
    issue32(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
    @(posedge clk); #1;
    chk("pre_rst_out_valid", 32'(bus32.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(bus32.out_valid), 32'd0);
    chk("async_rst_result", bus32.result, 32'd0);
    chk("async_rst_flags", 32'(bus32.flags), 32'd0);
    q32.delete();
    q16.delete();
    held32_v = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus32.in_ready), 32'd1);
    @(posedge clk); #1;

    // Latency after reset: out_valid exactly 3 cycles after acceptance.
    issue32(32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000);
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (bus32.out_valid) break;
    end
    chk("latency", 32'(n), 32'd3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpm_pipe.md
# fpm_pipe

Parametrised, pipelined IEEE-754 floating-point multiplier with valid/ready handshake, round-to-nearest-even and exception flags. It is the streaming successor of the combinational `fpm`. Exponent and mantissa widths are generic: binary32 by default, binary16 supported. It sits between operand producers and the FP result bus in the datapath and accepts one operation per cycle under no backpressure.

## Interface
- `EXP_W`, 8, exponent field width (≥3)
- `MAN_W`, 23, stored fraction width (≥2); word width `W = 1+EXP_W+MAN_W`
- `clk` in 1: the block's single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: operand pair valid
- `in_ready` out 1: block can accept operands this cycle
- `num1`, `num2` in W: operands, {sign, exponent, fraction}
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts result
- `result` out W: packed product
- `flags` out 4: {invalid, overflow, underflow, inexact}

## Operation
- BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1 (all-ones exponent).
- Classification per operand:
  - exp==0 → ZERO; subnormals are flushed to zero on input, with no flag.
  - exp==EMAX with frac==0 → INF.
  - exp==EMAX with frac MSB=1 → QNAN.
  - exp==EMAX otherwise → SNAN.
  - all else → NORM.
- Sign of result = s1 XOR s2, except NaN results.
- Special cases, priority order:
  1. Either operand NaN → canonical qNaN `{0, EMAX, 1, 0…}`; invalid=1 only if either operand is SNAN.
  2. INF × ZERO → canonical qNaN, invalid=1.
  3. INF × (INF or NORM) → signed infinity, no flags.
  4. ZERO × (ZERO or NORM) → signed zero, no flags.
- NORM × NORM:
  - Exponent: e = E1+E2−BIAS, computed in EXP_W+2-bit signed arithmetic.
  - Significand: P = {1,M1}×{1,M2}, 2·(MAN_W+1) bits. If P MSB is set, shift right 1 and e+=1.
  - Rounding: keep MAN_W fraction bits, guard = next bit, sticky = OR of the rest. Round-to-nearest-even: increment when guard & (sticky | LSB). Rounding carry-out renormalises and sets e+=1.
  - inexact = guard | sticky.
  - e ≥ EMAX → signed infinity, overflow=1, inexact=1.
  - e ≤ 0 → signed zero, underflow=1, inexact=1. Outputs are flushed, never subnormal.

## Timing
- Fixed 3-stage pipeline:
  - S1: classify, sign, exponent sum, registered.
  - S2: significand multiply, registered.
  - S3: normalise, round, pack; drives `result`/`flags` registers.
- Latency is 3 cycles from accepting handshake (`in_valid & in_ready`) to `out_valid`.
- Global stall: `stall = out_valid & ~out_ready`; `in_ready = ~stall`. While stalled, every stage register and valid bit holds.
- Throughput is 1 op/cycle with `out_ready` high. Capacity is 3 ops in flight; nothing is dropped or reordered.
- `result`, `flags` hold stable while `out_valid & ~out_ready`.
- Reset (asynchronous, any time, including mid-operation): all stage valid bits = 0, `out_valid`=0, `result`=0, `flags`=0. In-flight ops are discarded. `in_ready`=1 in the first cycle after release.
- Pipeline bubbles (`in_valid`=0) propagate as `out_valid`=0 slots.

## Structure
- Package `fpm_pkg`:
  - `fp_class_e` enum {ZERO, NORM, INF, QNAN, SNAN}
  - flag index constants `FLG_INV`, `FLG_OVF`, `FLG_UNF`, `FLG_INX`
  - functions computing BIAS/EMAX from EXP_W
- Sub-module `fpm_unpack` (combinational, parameters EXP_W/MAN_W): splits a word into sign/exp/significand-with-hidden-bit and class. Instantiated twice in S1.
- Multiplier is plain `*` on the registered significands; the synthesis tool may retime it.

## Test plan
- binary32, `out_ready`=1: 0x40800000 × 0x40A00000 → 0x41A00000 after 3 cycles, flags 0; 0x3FC00000 × 0x3FC00000 → 0x40100000.
- Rounding tie: 0x3F800800 × 0x3F800800 → 0x3F801000 (ties-to-even, round down), inexact=1 only.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1.
  - 0x7F000000 × 0x40000000 → 0x7F800000, overflow+inexact.
  - 0x00800000 × 0x3F000000 → 0x00000000, underflow+inexact.
  - 0x80000000 × 0x40A10020 → 0x80000000, flags 0.
- Backpressure: 6 back-to-back ops, `out_ready` low cycles 4–8. `in_ready` drops while stalled, `result` stable, all 6 results appear in order, none lost or duplicated.
- Reset: assert `rst_n` low with 2 ops in flight → outputs 0 immediately. After release, a new op completes in exactly 3 cycles and no stale result appears.
- binary16 (EXP_W=5, MAN_W=10): 0x4400 × 0x4500 → 0x4D00; 0x7BFF × 0x4000 → 0x7C00, overflow+inexact.
